// File: rtl/lzss_decoder_if.sv
// Token-in / word-out bus of the LZSS decompressor.
// err_o is present only when LZSS_DEC_ERR_CHECK_EN is defined.
interface lzss_decoder_if #(
    parameter int WORD_SIZE = 4
);
    logic                 w_en;
    logic [WORD_SIZE:0]   data_i;
    logic                 i_ready;
    logic [WORD_SIZE-1:0] data_o;
    logic                 o_valid;

`ifdef LZSS_DEC_ERR_CHECK_EN
    logic                 err_o;

    modport master (output w_en, data_i, input  i_ready, data_o, o_valid, err_o);
    modport slave  (input  w_en, data_i, output i_ready, data_o, o_valid, err_o);
`else
    modport master (output w_en, data_i, input  i_ready, data_o, o_valid);
    modport slave  (input  w_en, data_i, output i_ready, data_o, o_valid);
`endif
endinterface

// File: rtl/lzss_decoder.sv
// Streaming LZSS decompressor: literals pass through, references replay one history word per cycle.
// Optional sticky illegal-reference detection is built when LZSS_DEC_ERR_CHECK_EN is defined.
module lzss_decoder #(
    parameter int WORD_SIZE       = 4,
    parameter int WINDOW_SIZE     = 16,
    parameter int LOOK_AHEAD_SIZE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    lzss_decoder_if.slave bus
);
    localparam int PTR_W = $clog2(WINDOW_SIZE);
    localparam int LEN_W = $clog2(LOOK_AHEAD_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        GET_LEN,
        COPY
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [PTR_W-1:0]     wptr;
    logic [PTR_W-1:0]     dist_m1;
    logic [LEN_W-1:0]     cnt_m1;
    logic [WORD_SIZE-1:0] hist [WINDOW_SIZE];

    logic                 take;
    logic                 wr_en;
    logic [WORD_SIZE-1:0] wr_word;
    logic [PTR_W-1:0]     rd_ptr;

    assign bus.i_ready = (state != COPY);
    assign take        = bus.w_en && bus.i_ready;
    // dist = dist_m1 + 1; the subtraction wraps modulo the window.
    assign rd_ptr      = wptr - dist_m1 - PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path can infer a latch.
        state_nx = state;
        wr_en    = 1'b0;
        wr_word  = bus.data_i[WORD_SIZE-1:0];
        case (state)
            IDLE: begin
                if (take) begin
                    if (bus.data_i[WORD_SIZE]) state_nx = GET_LEN;
                    else                       wr_en    = 1'b1;
                end
            end
            GET_LEN: begin
                if (take) state_nx = COPY;
            end
            COPY: begin
                wr_en   = 1'b1;
                wr_word = hist[rd_ptr];
                if (cnt_m1 == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            dist_m1     <= '0;
            cnt_m1      <= '0;
            bus.data_o  <= '0;
            bus.o_valid <= 1'b0;
            // NOTE: the history is reset explicitly because a never-written slot must read as zero.
            for (int i = 0; i < WINDOW_SIZE; i++) hist[i] <= '0;
        end else begin
            bus.o_valid <= wr_en;
            if (wr_en) begin
                bus.data_o <= wr_word;
                hist[wptr] <= wr_word;
                wptr       <= wptr + PTR_W'(1);
            end
            if (state == IDLE && take) dist_m1 <= bus.data_i[PTR_W-1:0];
            if (state == GET_LEN && take) cnt_m1 <= bus.data_i[LEN_W-1:0];
            else if (state == COPY)       cnt_m1 <= cnt_m1 - LEN_W'(1);
        end
    end

`ifdef LZSS_DEC_ERR_CHECK_EN
    // Words written since reset, saturating at the window depth.
    logic [PTR_W:0] fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill      <= '0;
            bus.err_o <= 1'b0;
        end else begin
            if (wr_en && fill != (PTR_W + 1)'(WINDOW_SIZE)) fill <= fill + (PTR_W + 1)'(1);
            // dist > fill is the same test as dist_m1 >= fill.
            if (state == GET_LEN && take && ({1'b0, dist_m1} >= fill)) bus.err_o <= 1'b1;
        end
    end
`endif
endmodule
